// File: rtl/spu_pkg.sv
// Shared definitions for the SPU register-fetch stage and the execution units it feeds.
package spu_pkg;

  localparam int unsigned NUM_REGS = 128;
  localparam int unsigned REG_W    = 128;
  localparam int unsigned ADDR_W   = 7;

  localparam logic [10:0] OP_NOP = 11'b0;
  localparam logic [2:0]  FMT_RR = 3'd0;

  // Operand bundle presented to every execution unit at its RF/FWD stage.
  typedef struct packed {
    logic [10:0]       op;
    logic [2:0]        format;
    logic [ADDR_W-1:0] rt_addr;
    logic [REG_W-1:0]  ra;
    logic [REG_W-1:0]  rb;
    logic [17:0]       imm;
    logic              reg_write;
  } issue_t;

  // A nop is the all-zero opcode in RR format.
  function automatic logic is_nop(input logic [10:0] op, input logic [2:0] format);
    return (op == OP_NOP) && (format == FMT_RR);
  endfunction

endpackage

// File: rtl/spu_scoreboard.sv
// Per-register busy scoreboard: set on issue, clear on writeback, set wins on a
// same-address collision. Lookups see a same-cycle writeback as already cleared.
module spu_scoreboard
  import spu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] qa_addr,
  input  logic [ADDR_W-1:0] qb_addr,
  input  logic [ADDR_W-1:0] qt_addr,
  output logic              ebusy_a,
  output logic              ebusy_b,
  output logic              ebusy_t,
  output logic [7:0]        busy_count
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [7:0]          count_next;

  // Effective busy: a writeback landing this cycle releases the register now.
  assign ebusy_a = busy[qa_addr] && !(clr_en && (clr_addr == qa_addr));
  assign ebusy_b = busy[qb_addr] && !(clr_en && (clr_addr == qb_addr));
  assign ebusy_t = busy[qt_addr] && !(clr_en && (clr_addr == qt_addr));

  // Next busy vector: clear first so a same-address set overrides it.
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_addr] = 1'b0;
    if (set_en) busy_next[set_addr] = 1'b1;
  end

  // Popcount of the next vector so busy_count tracks busy in the same cycle.
  always_comb begin
    count_next = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      count_next = count_next + {7'b0, busy_next[i]};
    end
  end

  // Busy state and its count.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

endmodule

// File: rtl/spu_reg_fetch.sv
// Register-fetch / forwarding stage: reads the register table with writeback
// bypass, stalls decode on RAW/WAW hazards and registers the issue bundle.
module spu_reg_fetch
  import spu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic [10:0]       dec_op,
  input  logic [2:0]        dec_format,
  input  logic [ADDR_W-1:0] dec_ra_addr,
  input  logic [ADDR_W-1:0] dec_rb_addr,
  input  logic              dec_ra_used,
  input  logic              dec_rb_used,
  input  logic [ADDR_W-1:0] dec_rt_addr,
  input  logic [17:0]       dec_imm,
  input  logic              dec_reg_write,
  output logic              stall,
  output logic [10:0]       op,
  output logic [2:0]        format,
  output logic [ADDR_W-1:0] rt_addr,
  output logic [REG_W-1:0]  ra,
  output logic [REG_W-1:0]  rb,
  output logic [17:0]       imm,
  output logic              reg_write,
  input  logic [REG_W-1:0]  rt_wb,
  input  logic [ADDR_W-1:0] rt_addr_wb,
  input  logic              reg_write_wb,
  output logic [7:0]        busy_count
);

  logic [REG_W-1:0] regs [NUM_REGS];
  logic             nop;
  logic             issue_live;
  logic             ebusy_a;
  logic             ebusy_b;
  logic             ebusy_t;
  logic [REG_W-1:0] ra_val;
  logic [REG_W-1:0] rb_val;
  issue_t           issue_d;
  issue_t           issue_q;

  assign nop = is_nop(dec_op, dec_format);

  assign stall = dec_valid && !nop &&
                 ((dec_ra_used && ebusy_a) ||
                  (dec_rb_used && ebusy_b) ||
                  (dec_reg_write && ebusy_t));

  assign issue_live = dec_valid && !nop && !stall;

  spu_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .set_en     (issue_live && dec_reg_write),
    .set_addr   (dec_rt_addr),
    .clr_en     (reg_write_wb),
    .clr_addr   (rt_addr_wb),
    .qa_addr    (dec_ra_addr),
    .qb_addr    (dec_rb_addr),
    .qt_addr    (dec_rt_addr),
    .ebusy_a    (ebusy_a),
    .ebusy_b    (ebusy_b),
    .ebusy_t    (ebusy_t),
    .busy_count (busy_count)
  );

  // Operand read with writeback bypass; unused sources read as zero.
  always_comb begin
    ra_val = '0;
    rb_val = '0;
    if (dec_ra_used) begin
      ra_val = (reg_write_wb && (rt_addr_wb == dec_ra_addr)) ? rt_wb : regs[dec_ra_addr];
    end
    if (dec_rb_used) begin
      rb_val = (reg_write_wb && (rt_addr_wb == dec_rb_addr)) ? rt_wb : regs[dec_rb_addr];
    end
  end

  // Issue bundle: live instruction fields or an all-zero bubble.
  always_comb begin
    issue_d = '0;
    if (issue_live) begin
      issue_d.op        = dec_op;
      issue_d.format    = dec_format;
      issue_d.rt_addr   = dec_rt_addr;
      issue_d.ra        = ra_val;
      issue_d.rb        = rb_val;
      issue_d.imm       = dec_imm;
      issue_d.reg_write = dec_reg_write;
    end
  end

  // Pipeline register toward the execution units.
  always_ff @(posedge clk) begin
    if (reset) issue_q <= '0;
    else       issue_q <= issue_d;
  end

  // Register table: cleared on reset, written by the execution-unit writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (reg_write_wb) begin
      regs[rt_addr_wb] <= rt_wb;
    end
  end

  assign op        = issue_q.op;
  assign format    = issue_q.format;
  assign rt_addr   = issue_q.rt_addr;
  assign ra        = issue_q.ra;
  assign rb        = issue_q.rb;
  assign imm       = issue_q.imm;
  assign reg_write = issue_q.reg_write;

endmodule

// File: tb/tb_spu_reg_fetch.sv
// Bench for spu_reg_fetch: a register/busy-array model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_spu_reg_fetch;

  logic         clk = 1'b0;
  logic         reset;
  logic         dec_valid;
  logic [10:0]  dec_op;
  logic [2:0]   dec_format;
  logic [6:0]   dec_ra_addr;
  logic [6:0]   dec_rb_addr;
  logic         dec_ra_used;
  logic         dec_rb_used;
  logic [6:0]   dec_rt_addr;
  logic [17:0]  dec_imm;
  logic         dec_reg_write;
  logic         stall;
  logic [10:0]  op;
  logic [2:0]   format;
  logic [6:0]   rt_addr;
  logic [127:0] ra;
  logic [127:0] rb;
  logic [17:0]  imm;
  logic         reg_write;
  logic [127:0] rt_wb;
  logic [6:0]   rt_addr_wb;
  logic         reg_write_wb;
  logic [7:0]   busy_count;

  int tests = 0;
  int fails = 0;

  spu_reg_fetch dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_op(dec_op),
    .dec_format(dec_format), .dec_ra_addr(dec_ra_addr), .dec_rb_addr(dec_rb_addr),
    .dec_ra_used(dec_ra_used), .dec_rb_used(dec_rb_used), .dec_rt_addr(dec_rt_addr),
    .dec_imm(dec_imm), .dec_reg_write(dec_reg_write), .stall(stall), .op(op),
    .format(format), .rt_addr(rt_addr), .ra(ra), .rb(rb), .imm(imm),
    .reg_write(reg_write), .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb),
    .reg_write_wb(reg_write_wb), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  // Model state: the architectural register file, busy flags and expected outputs.
  bit [127:0] mregs [128];
  bit         mbusy [128];
  bit         mvalid = 1'b0;
  logic [10:0]  e_op;
  logic [2:0]   e_format;
  logic [6:0]   e_rt;
  logic [127:0] e_ra;
  logic [127:0] e_rb;
  logic [17:0]  e_imm;
  logic         e_rw;
  int           e_count;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_nop();
    return (dec_op == 11'd0) && (dec_format == 3'd0);
  endfunction

  // A register blocks decode if marked busy and not being written back this cycle.
  function automatic bit m_blocked(input logic [6:0] a);
    return mbusy[a] && !(reg_write_wb && rt_addr_wb == a);
  endfunction

  function automatic bit m_stall();
    if (!dec_valid || m_nop()) return 1'b0;
    return (dec_ra_used && m_blocked(dec_ra_addr)) ||
           (dec_rb_used && m_blocked(dec_rb_addr)) ||
           (dec_reg_write && m_blocked(dec_rt_addr));
  endfunction

  // Value an operand read sees: this cycle's writeback if it targets the address.
  function automatic logic [127:0] m_read(input logic [6:0] a);
    if (reg_write_wb && rt_addr_wb == a) return rt_wb;
    return mregs[a];
  endfunction

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step();
    bit go;
    if (reset) begin
      for (int i = 0; i < 128; i++) begin mregs[i] = '0; mbusy[i] = 1'b0; end
      {e_op, e_format, e_rt, e_ra, e_rb, e_imm, e_rw} = '0;
      mvalid = 1'b1;
    end else begin
      go = dec_valid && !m_nop() && !m_stall();
      if (go) begin
        e_op = dec_op; e_format = dec_format; e_rt = dec_rt_addr;
        e_ra = dec_ra_used ? m_read(dec_ra_addr) : '0;
        e_rb = dec_rb_used ? m_read(dec_rb_addr) : '0;
        e_imm = dec_imm; e_rw = dec_reg_write;
      end else begin
        {e_op, e_format, e_rt, e_ra, e_rb, e_imm, e_rw} = '0;
      end
      if (reg_write_wb) begin
        mregs[rt_addr_wb] = rt_wb;
        mbusy[rt_addr_wb] = 1'b0;
      end
      if (go && dec_reg_write) mbusy[dec_rt_addr] = 1'b1;
    end
    e_count = 0;
    for (int i = 0; i < 128; i++) e_count += int'(mbusy[i]);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("stall", {127'b0, stall}, {127'b0, m_stall()});
      chk("op", {117'b0, op}, {117'b0, e_op});
      chk("format", {125'b0, format}, {125'b0, e_format});
      chk("rt_addr", {121'b0, rt_addr}, {121'b0, e_rt});
      chk("ra", ra, e_ra);
      chk("rb", rb, e_rb);
      chk("imm", {110'b0, imm}, {110'b0, e_imm});
      chk("reg_write", {127'b0, reg_write}, {127'b0, e_rw});
      chk("busy_count", {120'b0, busy_count}, 128'(e_count));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    dec_valid = 0; dec_op = '0; dec_format = '0; dec_ra_addr = '0; dec_rb_addr = '0;
    dec_ra_used = 0; dec_rb_used = 0; dec_rt_addr = '0; dec_imm = '0; dec_reg_write = 0;
  endtask

  task automatic dec(input logic [10:0] o, input logic [2:0] f,
                     input logic [6:0] a, input logic au, input logic [6:0] b, input logic bu,
                     input logic [6:0] t, input logic w, input logic [17:0] i);
    dec_valid = 1; dec_op = o; dec_format = f; dec_ra_addr = a; dec_ra_used = au;
    dec_rb_addr = b; dec_rb_used = bu; dec_rt_addr = t; dec_reg_write = w; dec_imm = i;
  endtask

  task automatic wb(input logic en, input logic [6:0] a, input logic [127:0] v);
    reg_write_wb = en; rt_addr_wb = a; rt_wb = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [10:0] OP_CNTB = 11'b01010110100;
  localparam logic [10:0] OP_W    = 11'h040;

  logic [127:0] ones01;
  int bc;

  initial begin
    ones01 = {16{8'h01}};
    reset = 1; idle(); wb(0, '0, '0);
    tick(); tick();
    chk("reset op", {117'b0, op}, 128'd0);
    chk("reset busy_count", {120'b0, busy_count}, 128'd0);
    reset = 0;

    // Writeback r5, then cntb reads r5 and writes r6.
    wb(1, 7'd5, ones01); tick(); wb(0, '0, '0);
    dec(OP_CNTB, 3'd0, 7'd5, 1, 7'd0, 0, 7'd6, 1, 18'h1234); tick(); idle();
    chk("cntb ra", ra, ones01);
    chk("cntb op", {117'b0, op}, {117'b0, OP_CNTB});
    chk("cntb reg_write", {127'b0, reg_write}, 128'd1);
    chk("cntb imm", {110'b0, imm}, 128'h1234);
    chk("cntb busy_count", {120'b0, busy_count}, 128'd1);
    wb(1, 7'd6, 128'h66); tick(); wb(0, '0, '0);

    // RAW: reader of r10 stalls until the r10 writeback, which is bypassed.
    dec(OP_W, 3'd1, 7'd0, 0, 7'd0, 0, 7'd10, 1, '0); tick();
    dec(OP_CNTB, 3'd0, 7'd10, 1, 7'd0, 0, 7'd11, 1, '0); #1;
    for (int k = 0; k < 3; k++) begin
      chk("raw stall", {127'b0, stall}, 128'd1);
      tick();
      chk("raw bubble op", {117'b0, op}, 128'd0);
      chk("raw bubble reg_write", {127'b0, reg_write}, 128'd0);
    end
    wb(1, 7'd10, 128'hFF); #1;
    chk("raw release stall", {127'b0, stall}, 128'd0);
    tick(); idle(); wb(0, '0, '0);
    chk("raw bypass ra", ra, 128'hFF);
    wb(1, 7'd11, 128'h11); tick(); wb(0, '0, '0);

    // WAW: second writer of r3 holds until r3 writeback; set beats the clear.
    dec(OP_W, 3'd1, 7'd0, 0, 7'd0, 0, 7'd3, 1, '0); tick();
    dec(OP_W, 3'd1, 7'd0, 0, 7'd0, 0, 7'd3, 1, 18'h3); #1;
    chk("waw stall", {127'b0, stall}, 128'd1);
    tick(); tick();
    bc = int'(busy_count);
    wb(1, 7'd3, 128'h33); #1;
    chk("waw release stall", {127'b0, stall}, 128'd0);
    tick(); idle(); wb(0, '0, '0);
    chk("waw busy_count held", 128'(busy_count), 128'(bc));
    chk("waw issued rt", {121'b0, rt_addr}, 128'd3);

    // Nop with reg_write while r0 busy: no stall, bubble, no busy change.
    dec(OP_W, 3'd1, 7'd0, 0, 7'd0, 0, 7'd0, 1, '0); tick();
    bc = int'(busy_count);
    dec(11'd0, 3'd0, 7'd0, 1, 7'd0, 1, 7'd0, 1, 18'h2A); #1;
    chk("nop stall", {127'b0, stall}, 128'd0);
    tick(); idle();
    chk("nop op", {117'b0, op}, 128'd0);
    chk("nop imm", {110'b0, imm}, 128'd0);
    chk("nop busy_count", 128'(busy_count), 128'(bc));

    // Same source on both ports, then rb unused.
    wb(1, 7'd7, 128'hA5); tick(); wb(0, '0, '0);
    dec(OP_CNTB, 3'd0, 7'd7, 1, 7'd7, 1, 7'd20, 0, '0); tick();
    chk("dual ra", ra, 128'hA5);
    chk("dual rb", rb, 128'hA5);
    dec(OP_CNTB, 3'd0, 7'd7, 1, 7'd7, 0, 7'd20, 0, '0); tick(); idle();
    chk("rb unused ra", ra, 128'hA5);
    chk("rb unused rb", rb, 128'd0);

    // Writers in flight, then reset mid-operation.
    wb(1, 7'd3, 128'h3); tick(); wb(0, '0, '0);
    dec(OP_W, 3'd1, 7'd0, 0, 7'd0, 0, 7'd1, 1, '0); tick();
    dec(OP_W, 3'd1, 7'd0, 0, 7'd0, 0, 7'd2, 1, '0); tick();
    dec(OP_W, 3'd1, 7'd0, 0, 7'd0, 0, 7'd3, 1, '0); tick();
    idle(); reset = 1; tick(); reset = 0;
    chk("midreset op", {117'b0, op}, 128'd0);
    chk("midreset rt_addr", {121'b0, rt_addr}, 128'd0);
    chk("midreset busy_count", {120'b0, busy_count}, 128'd0);
    dec(OP_CNTB, 3'd0, 7'd1, 1, 7'd5, 1, 7'd9, 1, '0); #1;
    chk("post reset stall", {127'b0, stall}, 128'd0);
    tick(); idle();
    chk("post reset ra", ra, 128'd0);
    chk("post reset rb table cleared", rb, 128'd0);
    chk("post reset busy_count", {120'b0, busy_count}, 128'd1);

    // Writeback after reset still lands in the table.
    wb(1, 7'd9, 128'h99); tick(); wb(0, '0, '0);
    dec(OP_CNTB, 3'd0, 7'd9, 1, 7'd0, 0, 7'd12, 0, '0); tick(); idle();
    chk("wb after reset", ra, 128'h99);

    // Back-to-back independent issues.
    for (int k = 0; k < 4; k++) begin
      dec(OP_W + 11'(k), 3'd2, 7'd7, 1, 7'd0, 0, 7'(40 + k), 1, 18'(k));
      #1;
      chk("b2b stall", {127'b0, stall}, 128'd0);
      tick();
      chk("b2b op", {117'b0, op}, {117'b0, OP_W + 11'(k)});
    end
    idle(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
